// File: rtl/adder_seq_pkg.sv
// Shared types for the adder operand sequencer: FSM state encoding and default width.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_ADD  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 2;

endpackage

// File: rtl/adder_operand_sequencer_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and rising-edge
// detector producing a single-cycle load_pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic load_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  // The level only flips once the synced input has disagreed for the full window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign load_pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/adder_operand_sequencer.sv
// Operand entry FSM for an external WIDTH-bit adder: loads A then B/cin from
// switches on debounced button presses and captures {cout,sum} for display.
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_op,
  input  logic             sw_cin,
  input  logic             btn_load,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic [1:0]       state_led
);

  logic load_pulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_load),
    .load_pulse(load_pulse)
  );

  state_t           state_q, state_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             result_valid_q, result_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_A;
      add_a_q        <= '0;
      add_b_q        <= '0;
      add_cin_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      add_a_q        <= add_a_d;
      add_b_q        <= add_b_d;
      add_cin_q      <= add_cin_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    add_a_d        = add_a_q;
    add_b_d        = add_b_q;
    add_cin_d      = add_cin_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    if (btn_clr) begin
      state_d        = S_A;
      add_a_d        = '0;
      add_b_d        = '0;
      add_cin_d      = 1'b0;
      result_d       = '0;
      result_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (load_pulse) begin
            add_a_d = sw_op;
            state_d = S_B;
          end
        end
        S_B: begin
          if (load_pulse) begin
            add_b_d   = sw_op;
            add_cin_d = sw_cin;
            state_d   = S_ADD;
          end
        end
        // The adder has had a full cycle to settle on the registered operands.
        S_ADD: begin
          result_d       = {add_cout, add_sum};
          result_valid_d = 1'b1;
          state_d        = S_SHOW;
        end
        S_SHOW: begin
          if (load_pulse) begin
            result_valid_d = 1'b0;
            add_a_d        = sw_op;
            add_b_d        = '0;
            add_cin_d      = 1'b0;
            state_d        = S_B;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign add_cin      = add_cin_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign state_led    = state_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Scoreboard bench for adder_operand_sequencer with a behavioural adder a+b+cin.
module tb_adder_operand_sequencer;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_op = '0;
  logic         sw_cin = 1'b0;
  logic         btn_load = 1'b0;
  logic         btn_clr = 1'b0;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic [W:0]   result;
  logic         result_valid;
  logic [1:0]   state_led;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = add_a + add_b + {{W{1'b0}}, add_cin};

  adder_operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_op       (sw_op),
    .sw_cin      (sw_cin),
    .btn_load    (btn_load),
    .btn_clr     (btn_clr),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout),
    .result      (result),
    .result_valid(result_valid),
    .state_led   (state_led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Scoreboard consumer: each rising result_valid pops one expected sum.
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (u_dut.load_pulse) n_pulses++;
    if (result_valid && !rv_prev) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        check("sb_result", result, exp_q.pop_front());
        check("sb_state_show", state_led, 3);
      end
    end
    rv_prev = result_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn_load = 1'b1;
    tick(12);
    btn_load = 1'b0;
    tick(12);
  endtask

  task automatic load_b(input logic [W-1:0] b, input logic cin);
    sw_op  = b;
    sw_cin = cin;
    exp_q.push_back(add_a + b + {{W{1'b0}}, cin});
    press();
  endtask

  int cyc;
  int p0;
  logic seen_early;

  initial begin
    // 1. reset
    tick(3);
    check("rst_state", state_led, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_ops", {add_a, add_b, add_cin}, 0);
    rst_n = 1'b1;
    tick(10);
    check("post_rst_state", state_led, 0);
    check("post_rst_a", add_a, 0);

    // 2. 2 + 3 + 1 = 6
    sw_op = 2;
    press();
    check("t2_a", add_a, 2);
    check("t2_state_b", state_led, 1);
    sw_op = 3; sw_cin = 1;
    exp_q.push_back(3'b110);
    btn_load = 1'b1;
    cyc = 0;
    while (state_led != 2 && cyc < 30) begin tick(1); cyc++; end
    check("t2_reach_add", state_led, 2);
    check("t2_valid_not_yet", result_valid, 0);
    check("t2_b", add_b, 3);
    check("t2_cin", add_cin, 1);
    tick(1);
    check("t2_valid", result_valid, 1);
    check("t2_result", result, 3'b110);
    tick(11);
    btn_load = 1'b0;
    tick(12);
    check("t2_hold_show", state_led, 3);

    // 4. restart from S_SHOW
    sw_op = 1;
    press();
    check("t4_valid_clr", result_valid, 0);
    check("t4_a", add_a, 1);
    check("t4_b_zero", add_b, 0);
    check("t4_state", state_led, 1);
    load_b(1, 0);
    check("t4_result", result, 3'b010);

    // clear back to S_A
    btn_clr = 1'b1; tick(1); btn_clr = 1'b0;
    check("clr_state", state_led, 0);
    check("clr_all", {add_a, add_b, add_cin, result, result_valid}, 0);

    // 3. bounce: only a stable high yields a pulse
    sw_op = 2;
    p0 = n_pulses;
    seen_early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_load = ~btn_load;
      tick(1);
      if (state_led != 0) seen_early = 1'b1;
    end
    btn_load = 1'b1;
    cyc = 0;
    while (state_led == 0 && cyc < 30) begin tick(1); cyc++; end
    check("t3_no_early_change", seen_early, 0);
    check("t3_latency_in_range", (cyc >= 4 && cyc <= 9), 1);
    check("t3_a", add_a, 2);
    tick(10);
    btn_load = 1'b0;
    tick(12);
    check("t3_one_pulse", n_pulses - p0, 1);
    check("t3_state_b", state_led, 1);

    // 5. clear coincident with load pulse in S_B
    sw_op = 3;
    btn_load = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!u_dut.load_pulse && cyc < 30) begin @(negedge clk); cyc++; end
    btn_clr = 1'b1;
    tick(1);
    btn_clr = 1'b0;
    check("t5_state", state_led, 0);
    check("t5_a", add_a, 0);
    check("t5_b_not_loaded", add_b, 0);
    check("t5_valid", result_valid, 0);
    tick(8);
    btn_load = 1'b0;
    tick(12);
    check("t5_stay_a", state_led, 0);

    // 6. async reset while in S_ADD
    sw_op = 1;
    press();
    sw_op = 2; sw_cin = 1;
    btn_load = 1'b1;
    cyc = 0;
    while (state_led != 2 && cyc < 30) begin tick(1); cyc++; end
    check("t6_reach_add", state_led, 2);
    rst_n = 1'b0;
    btn_load = 1'b0;
    #1;
    check("t6_rst_state", state_led, 0);
    check("t6_rst_result", result, 0);
    check("t6_rst_valid", result_valid, 0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("t6_after_rst", {state_led, result, result_valid}, 0);
    sw_op = 3;
    press();
    load_b(3, 1);
    check("t6_wrap_result", result, 7);
    check("t6_carry_bit", result[W], 1);

    tick(3);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
